tag_ram_ctrl: RTL
=================

# tag_ram_ctrl

Sequencer and arbiter for the 2-way, 128-set L1 tag RAM. After reset it runs the tag RAM's clear sweep. It then shares the single tag-RAM address port among three requesters: pipeline lookups, refill writes from the miss handler, and CACHE-op invalidates. It computes hit, way and victim from the registered tag RAM output and issues all tag writes, including optional LRU/dirty updates on hit.

## Interface
- SET_WIDTH, 7, set index width; the sweep length is 2^SET_WIDTH cycles.
- TAG_WIDTH, 20, physical tag width. Per-way tag field is {valid, tag} = TAG_WIDTH+1 bits.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done  out  1  sweep finished; controller operational
- lookup_req  in  1  lookup request
- lookup_set  in  SET_WIDTH  set index
- lookup_tag  in  TAG_WIDTH  compare tag
- lookup_wr  in  1  store access; sets dirty on hit
- lookup_ready  out  1  lookup accepted when req&ready
- resp_valid  out  1  response strobe, 1 cycle
- resp_hit  out  1  hit
- resp_way  out  1  hit way; victim way on miss
- resp_victim_dirty  out  1  victim valid and dirty
- resp_victim_tag  out  TAG_WIDTH  victim tag for writeback
- refill_req  in  1  refill write request, held until ack
- refill_set  in  SET_WIDTH  refill set
- refill_way  in  1  way to install
- refill_tag  in  TAG_WIDTH  tag to install
- refill_dirty  in  1  install dirty (write-allocate store)
- refill_ack  out  1  1-cycle pulse on the write cycle
- inv_req  in  1  invalidate whole set, held until ack
- inv_set  in  SET_WIDTH  set to invalidate
- inv_ack  out  1  1-cycle pulse on the write cycle
- tr_raddr, tr_waddr  out  SET_WIDTH  tag RAM addresses
- tr_we  out  2  per-way write enable
- tr_din  out  45  write data
- tr_refill  out  1  tag-field write qualifier
- tr_load_over  out  1  selects waddr without a tag-field write
- tr_cache_reset  out  1  low = sweep clear
- tr_dout  in  45  registered tag RAM output

## Operation
- Entry layout:
  - [20:0] way0 {valid,tag}
  - [21] way0 dirty
  - [42:22] way1 {valid,tag}
  - [43] way1 dirty
  - [44] LRU: value = least-recently-used way.
- States: INIT, IDLE, RESP.
- INIT:
  - tr_cache_reset=0; sweep counter counts 0..2^SET_WIDTH-1.
  - On the terminal count: go to IDLE, init_done=1, tr_cache_reset=1.
- IDLE write arbitration, priority refill > invalidate. A write is issued only when no RESP write is pending.
- Refill write:
  - tr_refill=1, tr_waddr=refill_set, tr_we=one-hot(refill_way).
  - Way field = {1,refill_tag}; dirty=refill_dirty; LRU=~refill_way.
  - refill_ack the same cycle.
- Invalidate write:
  - tr_refill=1, tr_we=2'b11, tr_din=0.
  - inv_ack the same cycle.
- Lookup:
  - lookup_ready=1 in IDLE only when no write is issued that cycle.
  - Accept drives tr_raddr=lookup_set, latches tag/set/wr, moves to RESP.
- RESP (one cycle):
  - resp_valid=1.
  - hit_i = valid_i & tag_i==latched tag. If both ways hit, way0 is reported.
  - Miss victim selection: the invalid way0 first, then the invalid way1, then the LRU way.
  - resp_victim_dirty = victim valid & dirty; resp_victim_tag = victim tag field.
  - Next state is IDLE.
- tr_we=0, tr_refill=0, tr_load_over=0 whenever no write is issued.
- rst in any state: return to INIT, abort the pending response, no acks, sweep restarts from 0.
- Requests arriving during INIT are held off: ready=0, no acks.

## Timing
- Reset values:
  - init_done=0, lookup_ready=0, resp_valid=0, refill_ack=0, inv_ack=0.
  - tr_cache_reset=0, tr_we=0, tr_refill=0, tr_load_over=0.
  - Address and data outputs 0.
- init_done rises exactly 2^SET_WIDTH cycles after rst deasserts.
- Lookup latency: accept at cycle T, resp_valid at T+1.
- Write visibility: a write at cycle T is visible to a lookup accepted at T+1 or later.
- Refill/inv ack latency: minimum 0 cycles after req sampled in IDLE; acks never occur in INIT.

## Configuration
- TAG_CTRL_LRU_UPDATE_EN defined:
  - On a RESP hit, the same cycle issues a write with tr_load_over=1, tr_refill=0, tr_waddr=latched set, tr_we=one-hot(hit way).
  - Written dirty = old dirty | lookup_wr; written LRU = ~hit way.
  - lookup_ready=0 during RESP, so one lookup per 2 cycles.
  - Refill/inv wait while this write is pending.
- Undefined:
  - No hit writes; LRU changes only on refill.
  - lookup_ready may be 1 in RESP, allowing back-to-back lookups at 1 per cycle; IDLE arbitration rules apply in RESP.

## Test plan
- Reset release -> tr_cache_reset low for 128 cycles, then init_done=1; a lookup of any set misses with resp_way=0 and resp_victim_dirty=0.
- Refill set 5, way1, tag 0x12345, dirty=1, then lookup set 5 tag 0x12345 -> resp_hit=1, resp_way=1 at accept+1.
- Fill both ways of set 9 (refill way0 then way1), then lookup a miss tag -> victim way0; with LRU_UPDATE_EN, a hit on way0 first makes the victim way1.
- Refill and invalidate both asserted in the same cycle -> refill_ack first, inv_ack next cycle; set is all-invalid afterwards.
- Store hit on clean way0 with LRU_UPDATE_EN -> tr_we=01, tr_load_over=1; a later miss to that set reports resp_victim_dirty=1 if way0 is chosen.
- rst asserted in RESP -> no resp_valid; sweep restarts from set 0; 128 cycles later every set reads invalid.

Source files
------------

// File: rtl/tag_ram_ctrl.sv
// Tag RAM sequencer/arbiter for a 2-way L1: clear sweep, refill/invalidate writes, lookups with hit/victim.
// Optional hit-time LRU/dirty writeback is enabled by defining TAG_CTRL_LRU_UPDATE_EN.
`timescale 1ns/1ps
module tag_ram_ctrl #(
   parameter int SET_WIDTH = 7,
   parameter int TAG_WIDTH = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   init_done,
   input  logic                   lookup_req,
   input  logic [SET_WIDTH-1:0]   lookup_set,
   input  logic [TAG_WIDTH-1:0]   lookup_tag,
   input  logic                   lookup_wr,
   output logic                   lookup_ready,
   output logic                   resp_valid,
   output logic                   resp_hit,
   output logic                   resp_way,
   output logic                   resp_victim_dirty,
   output logic [TAG_WIDTH-1:0]   resp_victim_tag,
   input  logic                   refill_req,
   input  logic [SET_WIDTH-1:0]   refill_set,
   input  logic                   refill_way,
   input  logic [TAG_WIDTH-1:0]   refill_tag,
   input  logic                   refill_dirty,
   output logic                   refill_ack,
   input  logic                   inv_req,
   input  logic [SET_WIDTH-1:0]   inv_set,
   output logic                   inv_ack,
   output logic [SET_WIDTH-1:0]   tr_raddr,
   output logic [SET_WIDTH-1:0]   tr_waddr,
   output logic [1:0]             tr_we,
   output logic [2*TAG_WIDTH+4:0] tr_din,
   output logic                   tr_refill,
   output logic                   tr_load_over,
   output logic                   tr_cache_reset,
   input  logic [2*TAG_WIDTH+4:0] tr_dout
);

   localparam int W1 = TAG_WIDTH + 2;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESP} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [SET_WIDTH-1:0]   r_sweep;
   logic [TAG_WIDTH-1:0]   r_tag_p1;
   logic                   w_accept;
   logic                   w_arb;

   logic [TAG_WIDTH-1:0]   w_t0, w_t1;
   logic                   w_v0, w_v1, w_d0, w_d1, w_lru;
   logic                   w_hit0, w_hit1, w_hit, w_hit_way, w_victim;

   assign w_t0  = tr_dout[TAG_WIDTH-1:0];
   assign w_v0  = tr_dout[TAG_WIDTH];
   assign w_d0  = tr_dout[TAG_WIDTH+1];
   assign w_t1  = tr_dout[W1+TAG_WIDTH-1:W1];
   assign w_v1  = tr_dout[W1+TAG_WIDTH];
   assign w_d1  = tr_dout[W1+TAG_WIDTH+1];
   assign w_lru = tr_dout[2*W1];

   assign w_hit0    = w_v0 & (w_t0 == r_tag_p1);
   assign w_hit1    = w_v1 & (w_t1 == r_tag_p1);
   assign w_hit     = w_hit0 | w_hit1;
   assign w_hit_way = ~w_hit0;
   // Invalid ways are filled before anything valid is evicted.
   assign w_victim  = ~w_v0 ? 1'b0 : (~w_v1 ? 1'b1 : w_lru);

   assign w_accept  = lookup_req & lookup_ready;

`ifdef TAG_CTRL_LRU_UPDATE_EN
   logic [SET_WIDTH-1:0]   r_set_p1;
   logic                   r_wr_p1;
   logic [2*TAG_WIDTH+4:0] w_lru_din;

   assign w_lru_din = {~w_hit_way, w_d1 | (r_wr_p1 & w_hit_way), w_v1, w_t1,
                       w_d0 | (r_wr_p1 & ~w_hit_way), w_v0, w_t0};

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_set_p1 <= lookup_set;
         r_wr_p1  <= lookup_wr;
      end
   end
`else
   logic w_unused_wr;
   assign w_unused_wr = lookup_wr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
         r_sweep <= '0;
      end else begin
         r_state <= w_next;
         r_sweep <= (r_state == S_INIT) ? r_sweep + 1'b1 : '0;
      end
   end

   // stage p0 -> p1: lookup tag captured alongside the RAM read
   always_ff @(posedge clk) begin
      if (w_accept) r_tag_p1 <= lookup_tag;
   end

   always_comb begin
      w_next            = r_state;
      w_arb             = 1'b0;
      init_done         = 1'b0;
      lookup_ready      = 1'b0;
      resp_valid        = 1'b0;
      resp_hit          = 1'b0;
      resp_way          = 1'b0;
      resp_victim_dirty = 1'b0;
      resp_victim_tag   = '0;
      refill_ack        = 1'b0;
      inv_ack           = 1'b0;
      tr_raddr          = '0;
      tr_waddr          = '0;
      tr_we             = 2'b00;
      tr_din            = '0;
      tr_refill         = 1'b0;
      tr_load_over      = 1'b0;
      tr_cache_reset    = 1'b0;
      // rst also masks the current cycle so an in-flight response is dropped
      if (!rst) begin
         unique case (r_state)
            S_INIT: begin
               tr_waddr = r_sweep;
               if (r_sweep == '1) w_next = S_IDLE;
            end
            default: begin
               init_done      = 1'b1;
               tr_cache_reset = 1'b1;
               w_arb          = 1'b1;
               if (r_state == S_RESP) begin
                  resp_valid        = 1'b1;
                  resp_hit          = w_hit;
                  resp_way          = w_hit ? w_hit_way : w_victim;
                  resp_victim_dirty = w_victim ? (w_v1 & w_d1) : (w_v0 & w_d0);
                  resp_victim_tag   = w_victim ? w_t1 : w_t0;
                  w_next            = S_IDLE;
`ifdef TAG_CTRL_LRU_UPDATE_EN
                  w_arb = 1'b0;
                  if (w_hit) begin
                     tr_load_over = 1'b1;
                     tr_waddr     = r_set_p1;
                     tr_we        = w_hit_way ? 2'b10 : 2'b01;
                     tr_din       = w_lru_din;
                  end
`endif
               end
               if (w_arb) begin
                  if (refill_req) begin
                     refill_ack = 1'b1;
                     tr_refill  = 1'b1;
                     tr_waddr   = refill_set;
                     tr_we      = refill_way ? 2'b10 : 2'b01;
                     tr_din     = {~refill_way, refill_dirty, 1'b1, refill_tag,
                                   refill_dirty, 1'b1, refill_tag};
                  end else if (inv_req) begin
                     inv_ack   = 1'b1;
                     tr_refill = 1'b1;
                     tr_waddr  = inv_set;
                     tr_we     = 2'b11;
                  end else begin
                     lookup_ready = 1'b1;
                     if (lookup_req) begin
                        tr_raddr = lookup_set;
                        w_next   = S_RESP;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule
